// File: rtl/ascon_block_unloader.sv
// Serial unloader for wide Ascon data/tag blocks: captures one BLOCK_W block in
// parallel and streams it MSB-first as WORD_W words with byte-keep and last flags.
module ascon_block_unloader #(
   parameter int BLOCK_W = 128,
   parameter int WORD_W  = 32
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [BLOCK_W-1:0]             in_data,
   input  logic [$clog2(BLOCK_W/8):0]     in_bytes,
   input  logic                           in_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WORD_W-1:0]              out_data,
   output logic [WORD_W/8-1:0]            out_keep,
   output logic                           out_last
);

   localparam int BLK_BYTES = BLOCK_W / 8;
   localparam int WB        = WORD_W / 8;
   localparam int NW        = BLOCK_W / WORD_W;
   localparam int CNT_W     = $clog2(BLK_BYTES) + 1;
   localparam int WC_W      = $clog2(NW + 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [BLOCK_W-1:0]  shreg_q, shreg_d;
   logic [WC_W-1:0]     wcnt_q, wcnt_d;
   logic [CNT_W-1:0]    bytes_q, bytes_d;
   logic                last_q, last_d;

   logic [CNT_W-1:0]    clamp_s;
   logic [CNT_W:0]      nw_wide_s;
   logic [WC_W-1:0]     cap_nwords_s;
   logic                cap_go_s;
   logic                final_s;
   logic                accept_s;

   // Capture-side decode: clamp the byte count and derive the word count.
   // An empty last block still produces one all-invalid terminator word.
   always_comb begin
      if (in_bytes > CNT_W'(BLK_BYTES)) begin
         clamp_s = CNT_W'(BLK_BYTES);
      end else begin
         clamp_s = in_bytes;
      end
      nw_wide_s    = ({1'b0, clamp_s} + (CNT_W+1)'(WB - 1)) / (CNT_W+1)'(WB);
      cap_nwords_s = WC_W'(nw_wide_s);
      cap_go_s     = (cap_nwords_s != {WC_W{1'b0}}) || in_last;
      if (cap_nwords_s == {WC_W{1'b0}}) begin
         cap_nwords_s = WC_W'(1);
      end else begin
         cap_nwords_s = cap_nwords_s;
      end
   end

   assign final_s  = (wcnt_q == WC_W'(1));
   assign accept_s = in_valid && in_ready;

   // State register plus datapath registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         shreg_q <= {BLOCK_W{1'b0}};
         wcnt_q  <= {WC_W{1'b0}};
         bytes_q <= {CNT_W{1'b0}};
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         wcnt_q  <= wcnt_d;
         bytes_q <= bytes_d;
         last_q  <= last_d;
      end
   end

   // Next-state logic; a block may be reloaded in the cycle its final word leaves.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_valid && cap_go_s) begin
               state_d = SEND;
            end else begin
               state_d = IDLE;
            end
         end
         SEND: begin
            if (out_ready && final_s) begin
               if (in_valid && cap_go_s) begin
                  state_d = SEND;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = SEND;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: load on capture, otherwise shift on each transfer.
   always_comb begin
      shreg_d = shreg_q;
      wcnt_d  = wcnt_q;
      bytes_d = bytes_q;
      last_d  = last_q;
      if (accept_s && cap_go_s) begin
         shreg_d = in_data;
         wcnt_d  = cap_nwords_s;
         bytes_d = clamp_s;
         last_d  = in_last;
      end else if ((state_q == SEND) && out_ready) begin
         shreg_d = shreg_q << WORD_W;
         wcnt_d  = wcnt_q - WC_W'(1);
         if (bytes_q > CNT_W'(WB)) begin
            bytes_d = bytes_q - CNT_W'(WB);
         end else begin
            bytes_d = {CNT_W{1'b0}};
         end
      end else begin
         shreg_d = shreg_q;
      end
   end

   // Output decode from registered state; bytes past the valid count read as 0.
   always_comb begin
      out_data  = {WORD_W{1'b0}};
      out_keep  = {WB{1'b0}};
      out_valid = 1'b0;
      out_last  = 1'b0;
      in_ready  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = reset_n;
         end
         SEND: begin
            out_valid = 1'b1;
            out_last  = last_q && final_s;
            in_ready  = reset_n && final_s && out_ready;
            for (int i = 0; i < WB; i++) begin
               if (CNT_W'(i) < bytes_q) begin
                  out_keep[WB-1-i]           = 1'b1;
                  out_data[WORD_W-1-8*i -: 8] = shreg_q[BLOCK_W-1-8*i -: 8];
               end else begin
                  out_keep[WB-1-i]           = 1'b0;
               end
            end
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_ascon_block_unloader.sv
// Directed bench for ascon_block_unloader: a table of single-block vectors streamed
// with out_ready high, plus sequences for backpressure, back-to-back and reset.
module tb_ascon_block_unloader;

   logic         clk;
   logic         reset_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [4:0]   in_bytes;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_data;
   logic [3:0]   out_keep;
   logic         out_last;

   int n_cmp = 0;
   int n_err = 0;

   ascon_block_unloader #(.BLOCK_W(128), .WORD_W(32)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_bytes  (in_bytes),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] data;
      logic [4:0]   bytes;
      logic         last;
      int           nexp;
      logic [127:0] exp_data;
      logic [15:0]  exp_keep;
      logic [3:0]   exp_last;
   } vec_t;

   vec_t vecs[9];

   localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] D2 = 128'hA1B2C3D4_E5F60718_293A4B5C_6D7E8F90;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_word(input string name, input logic [31:0] d, input logic [3:0] k,
                           input logic l);
      chk({name, ".valid"}, 32'(out_valid), 32'd1);
      chk({name, ".data"},  out_data, d);
      chk({name, ".keep"},  32'(out_keep), 32'(k));
      chk({name, ".last"},  32'(out_last), 32'(l));
   endtask

   task automatic offer(input logic [127:0] d, input logic [4:0] b, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_bytes = b;
      in_last  = l;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{D1, 5'd16, 1'b1, 4, D1, 16'hFFFF, 4'b0001};
      vecs[1] = '{D1, 5'd6,  1'b1, 2, {32'h00112233, 32'h44550000, 64'h0}, 16'hFC00, 4'b0100};
      vecs[2] = '{D1, 5'd0,  1'b1, 1, 128'h0, 16'h0000, 4'b1000};
      vecs[3] = '{D1, 5'd0,  1'b0, 0, 128'h0, 16'h0000, 4'b0000};
      vecs[4] = '{D1, 5'd20, 1'b0, 4, D1, 16'hFFFF, 4'b0000};
      vecs[5] = '{D2, 5'd1,  1'b0, 1, {32'hA1000000, 96'h0}, 16'h8000, 4'b0000};
      vecs[6] = '{D1, 5'd15, 1'b1, 4, {96'h00112233_44556677_8899AABB, 32'hCCDDEE00},
                  16'hFFFE, 4'b0001};
      vecs[7] = '{D2, 5'd31, 1'b1, 4, D2, 16'hFFFF, 4'b0001};
      vecs[8] = '{D1, 5'd5,  1'b1, 2, {32'h00112233, 32'h44000000, 64'h0}, 16'hF800, 4'b0100};

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = 128'h0;
      in_bytes  = 5'd0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out_data", out_data, 32'h0);
      chk("rst.out_keep", 32'(out_keep), 32'h0);
      chk("rst.out_last", 32'(out_last), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle.in_ready", 32'(in_ready), 32'd1);
      chk("idle.out_valid", 32'(out_valid), 32'd0);

      // Table-driven single blocks with out_ready held high
      for (int v = 0; v < 9; v++) begin
         @(negedge clk);
         chk($sformatf("v%0d.in_ready", v), 32'(in_ready), 32'd1);
         offer(vecs[v].data, vecs[v].bytes, vecs[v].last);
         out_ready = 1'b1;
         @(posedge clk);
         #1 in_valid = 1'b0;
         for (int k = 0; k < vecs[v].nexp; k++) begin
            @(negedge clk);
            chk_word($sformatf("v%0d.w%0d", v, k), vecs[v].exp_data[127-32*k -: 32],
                     vecs[v].exp_keep[15-4*k -: 4], vecs[v].exp_last[3-k]);
         end
         @(negedge clk);
         chk($sformatf("v%0d.end_valid", v), 32'(out_valid), 32'd0);
         chk($sformatf("v%0d.end_ready", v), 32'(in_ready), 32'd1);
      end

      // Backpressure: ready pattern 1,0,0,1,0,1,1 gives exactly four ordered transfers
      begin
         logic [6:0] pat;
         int idx;
         pat = 7'b1001011;
         idx = 0;
         @(negedge clk);
         offer(D1, 5'd16, 1'b1);
         @(posedge clk);
         #1 in_valid = 1'b0;
         for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            out_ready = pat[6-c];
            chk_word($sformatf("bp.c%0d", c), D1[127-32*idx -: 32], 4'hF, (idx == 3));
            @(posedge clk);
            if (pat[6-c]) idx++;
         end
         @(negedge clk);
         chk("bp.transfers", 32'(idx), 32'd4);
         chk("bp.end_valid", 32'(out_valid), 32'd0);
      end

      // Back-to-back: B is accepted in the cycle A's fourth word leaves
      out_ready = 1'b1;
      @(negedge clk);
      offer(D1, 5'd16, 1'b0);
      @(posedge clk);
      #1 offer(D2, 5'd16, 1'b1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk_word($sformatf("b2b.w%0d", k), (k < 4) ? D1[127-32*k -: 32] : D2[127-32*(k-4) -: 32],
                  4'hF, (k == 7));
         if (k < 4) chk($sformatf("b2b.in_ready%0d", k), 32'(in_ready), 32'((k == 3)));
         if (k == 3) begin
            @(posedge clk);
            #1 in_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("b2b.end_valid", 32'(out_valid), 32'd0);

      // Reset after the second word drops the rest of the block
      @(negedge clk);
      offer(D1, 5'd16, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk_word("rm.w0", 32'h00112233, 4'hF, 1'b0);
      @(negedge clk);
      chk_word("rm.w1", 32'h44556677, 4'hF, 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      chk("rm.out_valid", 32'(out_valid), 32'd0);
      chk("rm.out_data", out_data, 32'h0);
      chk("rm.out_keep", 32'(out_keep), 32'h0);
      chk("rm.out_last", 32'(out_last), 32'd0);
      chk("rm.in_ready_rst", 32'(in_ready), 32'd0);
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("rm.post%0d.in_ready", c), 32'(in_ready), 32'd1);
         chk($sformatf("rm.post%0d.out_valid", c), 32'(out_valid), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
